// File: rtl/ifu_prefetch.sv
// ifu_prefetch: owns the fetch PC, issues imem word requests, buffers in-order responses for decode.
// Optional IFU_ALIGN_CHECK_EN: a misaligned redirect target sets a sticky fetch_fault and halts fetch.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fetch_fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_pop;
  logic [SW-1:0] reserved;
  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];
  logic [31:0]   pcq_q  [DEPTH];
  logic [PW-1:0] pcq_wr_q, pcq_rd_q;
  logic          req_valid_q, req_valid_d;
  logic          inst_valid_q, inst_valid_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic          req_hs, rsp_drop, push, pop, bad_target;

`ifdef IFU_ALIGN_CHECK_EN
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign bad_target = 1'b0;
  assign unused_lsb = ^redirect_pc[1:0];
`endif

  assign req_hs   = req_valid_q && imem_req_ready;
  assign pop      = inst_valid_q && inst_ready;
  assign rsp_drop = imem_rsp_valid && (disc_q != '0);
  assign push     = imem_rsp_valid && !rsp_drop && !redirect_valid;

  // Datapath next state: counters, shift FIFO (head at index 0), redirect flush.
  always_comb begin
    fifo_d     = fifo_q;
    out_d      = out_q + CW'(req_hs) - CW'(imem_rsp_valid);
    disc_d     = rsp_drop ? disc_q - CW'(1) : disc_q;
    fetch_pc_d = req_hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
    fault_d    = fault_q;
    cnt_pop    = cnt_q - CW'(pop);
    cnt_d      = cnt_pop;
    if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        fifo_d[PW'(i)] = fifo_q[PW'(i + 1)];
      end
    end
    if (push) begin
      fifo_d[PW'(cnt_pop)].pc   = pcq_q[pcq_rd_q];
      fifo_d[PW'(cnt_pop)].data = imem_rsp_data;
      cnt_d                     = cnt_pop + CW'(1);
    end
    // Everything still in flight after this cycle is stale.
    if (redirect_valid) begin
      cnt_d      = '0;
      disc_d     = out_d;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      fault_d    = fault_q || bad_target;
    end
  end

  // Control FSM next state and registered-output next values.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (disc_d != '0) state_d = ST_DRAIN;
      ST_DRAIN: if (disc_d == '0) state_d = ST_RUN;
      ST_HALT:  if (!halt_req && !fault_d) state_d = (disc_d != '0) ? ST_DRAIN : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (halt_req || fault_d) state_d = ST_HALT;

    reserved     = SW'(cnt_d) + SW'(out_d);
    req_valid_d  = (state_d != ST_HALT) && (reserved < SW'(DEPTH));
    inst_valid_d = (cnt_d != '0);
    halted_d     = halt_req && (out_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      out_q        <= '0;
      disc_q       <= '0;
      cnt_q        <= '0;
      pcq_wr_q     <= '0;
      pcq_rd_q     <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      cnt_q        <= cnt_d;
      pcq_wr_q     <= pcq_wr_q + PW'(req_hs);
      pcq_rd_q     <= pcq_rd_q + PW'(imem_rsp_valid);
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (req_hs) pcq_q[pcq_wr_q] <= fetch_pc_q;
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_pc        = fifo_q[0].pc;
  assign inst_data      = fifo_q[0].data;
  assign halted         = halted_q;
  assign fetch_fault    = fault_q;

endmodule
